// File: rtl/noc_phase_sequencer_pkg.sv
// rtl/noc_phase_sequencer_pkg.sv - shared op codes, state encoding and op decode for the phase sequencer
package noc_phase_sequencer_pkg;

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_PHASE0  = 2'd2;
    localparam logic [1:0] OP_PHASE1  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PH0    = 3'd2,
        ST_PH1    = 3'd3,
        ST_FINISH = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    function automatic logic [1:0] op_for_state(input state_t s);
        case (s)
            ST_LOAD: return OP_LOAD;
            ST_PH0:  return OP_PHASE0;
            ST_PH1:  return OP_PHASE1;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/noc_phase_sequencer_watchdog.sv
// rtl/noc_phase_sequencer_watchdog.sv - per-phase clock counter, expired on the TIMEOUT-th clock in a phase
module noc_phase_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // The count holds completed clocks, so the current clock is the TIMEOUT-th when it equals TIMEOUT-1.
    assign expired = enable && (r_count >= CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/noc_phase_sequencer.sv
// rtl/noc_phase_sequencer.sv - LOAD/PH0/PH1 network-cycle sequencer for router arrays
// Optional watchdog and ERROR state enabled by SEQ_TIMEOUT_EN.
module noc_phase_sequencer
    import noc_phase_sequencer_pkg::*;
#(
    parameter int NUM_ROUTERS = 16,
    parameter int CYCLE_W     = 16,
    parameter int OP_W        = 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CYCLE_W-1:0]     num_cycles,
    input  logic [NUM_ROUTERS-1:0] done_vec,
    output logic [OP_W-1:0]        op,
    output logic                   stage_load,
    output logic [CYCLE_W-1:0]     in_cycle,
    output logic                   busy,
    output logic                   finished,
    output logic                   err
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_first;
    logic               r_all_done;
    logic [CYCLE_W-1:0] r_num;
    logic [CYCLE_W-1:0] r_in_cycle;
    logic [CYCLE_W-1:0] w_in_next;
    logic [CYCLE_W-1:0] w_inc;
    logic [OP_W-1:0]    r_op;
    logic               r_stage_load;
    logic               r_busy;
    logic               r_finished;
    logic               w_in_phase;
    logic               w_exit;
    logic               w_expired;
    logic               w_start_ok;
    logic               w_stage_next;

    assign w_in_phase = (r_state == ST_PH0) || (r_state == ST_PH1);
    // all_done is registered, so a phase always lasts at least two clocks.
    assign w_exit     = w_in_phase && !r_first && r_all_done;
    assign w_inc      = r_in_cycle + 1'b1;
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;

    always_comb begin
        w_state_next = r_state;
        w_in_next    = r_in_cycle;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_in_next    = '0;
                    w_state_next = (num_cycles == '0) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD: w_state_next = ST_PH0;
            ST_PH0: begin
                if (w_exit) begin
                    w_state_next = ST_PH1;
                end else if (w_expired) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_PH1: begin
                if (w_exit) begin
                    w_in_next    = w_inc;
                    w_state_next = (w_inc == r_num) ? ST_FINISH : ST_LOAD;
                end else if (w_expired) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_FINISH: w_state_next = ST_IDLE;
`ifdef SEQ_TIMEOUT_EN
            ST_ERROR: w_state_next = ST_ERROR;
`endif
            default: w_state_next = ST_IDLE;
        endcase
        if (abort) begin
            w_state_next = ST_IDLE;
            w_in_next    = r_in_cycle;
        end
    end

    // Staging pulse for PH1 exit lands on the last PH1 clock: it is the clock whose registered all_done is high.
    assign w_stage_next = (w_state_next == ST_LOAD) ||
                          ((w_state_next == ST_PH1) && (r_state == ST_PH1) && (&done_vec));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_first      <= 1'b1;
            r_all_done   <= 1'b0;
            r_num        <= '0;
            r_in_cycle   <= '0;
            r_op         <= '0;
            r_stage_load <= 1'b0;
            r_busy       <= 1'b0;
            r_finished   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_first      <= (w_state_next != r_state);
            r_all_done   <= &done_vec;
            if (w_start_ok) begin
                r_num <= num_cycles;
            end
            r_in_cycle   <= w_in_next;
            r_op         <= OP_W'(op_for_state(w_state_next));
            r_stage_load <= w_stage_next;
            r_busy       <= (w_state_next != ST_IDLE);
            r_finished   <= (w_state_next == ST_FINISH);
        end
    end

`ifdef SEQ_TIMEOUT_EN
    logic r_err;
    logic w_wd_clear;

    assign w_wd_clear = ((w_state_next == ST_PH0) || (w_state_next == ST_PH1)) &&
                        (w_state_next != r_state);

    noc_phase_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_wd_clear),
        .enable  (w_in_phase),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_state_next == ST_ERROR) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_expired        = 1'b0;
    assign err              = 1'b0;
`endif

    assign op         = r_op;
    assign stage_load = r_stage_load;
    assign in_cycle   = r_in_cycle;
    assign busy       = r_busy;
    assign finished   = r_finished;

endmodule

// File: tb/tb_noc_phase_sequencer.sv
// tb/tb_noc_phase_sequencer.sv - randomized bench against an expected-trace model of the phase sequencer
module tb_noc_phase_sequencer;

    localparam int NR = 16;
    localparam int CW = 4;
    localparam int OW = 3;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_cycles = '0;
    logic [NR-1:0] done_vec = '0;
    logic [OW-1:0] op;
    logic          stage_load;
    logic [CW-1:0] in_cycle;
    logic          busy;
    logic          finished;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;
    int n_sl     = 0;

    always #5 clk = ~clk;

    noc_phase_sequencer #(
        .NUM_ROUTERS (NR),
        .CYCLE_W     (CW),
        .OP_W        (OW),
        .TIMEOUT     (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .num_cycles (num_cycles),
        .done_vec   (done_vec),
        .op         (op),
        .stage_load (stage_load),
        .in_cycle   (in_cycle),
        .busy       (busy),
        .finished   (finished),
        .err        (err)
    );

    // One expected clock: outputs to see during it, inputs to drive during it.
    typedef struct packed {
        logic [OW-1:0] op;
        logic          sl;
        logic [CW-1:0] inc;
        logic          busy;
        logic          fin;
        logic [NR-1:0] done;
        logic          start;
        logic          abort;
        logic [CW-1:0] num;
    } cyc_t;

    cyc_t          tr[$];
    logic [CW-1:0] m_in = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [NR-1:0] not_all_done();
        logic [NR-1:0] v;
        v = NR'($urandom);
        v[$urandom_range(NR-1, 0)] = 1'b0;
        return v;
    endfunction

    function automatic cyc_t mk(input int o, input bit sl, input int inc, input bit b,
                                input bit f, input logic [NR-1:0] d);
        cyc_t r;
        r.op    = OW'(o);
        r.sl    = sl;
        r.inc   = CW'(inc);
        r.busy  = b;
        r.fin   = f;
        r.done  = d;
        r.start = b ? ($urandom_range(3) == 0) : 1'b0;
        r.abort = 1'b0;
        r.num   = CW'($urandom);
        return r;
    endfunction

    // A run is LOAD, PH0 for k0+1 clocks, PH1 for k1+1 clocks per network cycle, then FINISH, IDLE.
    // k is the phase clock on which every router reports done; kx=0 picks it at random.
    task automatic build_run(input int n, input int k0, input int k1, input bit bit5_only);
        cyc_t r;
        tr.delete();
        r = mk(0, 0, int'(m_in), 0, 0, NR'($urandom));
        r.start = 1'b1;
        r.num   = CW'(n);
        tr.push_back(r);
        for (int c = 0; c < n; c++) begin
            tr.push_back(mk(1, 1, c, 1, 0, NR'($urandom)));
            for (int ph = 0; ph < 2; ph++) begin
                int k;
                k = (ph == 0) ? k0 : k1;
                if (k == 0) k = $urandom_range(6, 1);
                for (int j = 1; j <= k + 1; j++) begin
                    logic [NR-1:0] d;
                    if (j >= k) d = '1;
                    else if (bit5_only) d = ~(NR'(1) << 5);
                    else d = not_all_done();
                    tr.push_back(mk(2 + ph, (ph == 1) && (j == k + 1), c, 1, 0, d));
                end
            end
        end
        tr.push_back(mk(0, 0, n, 1, 1, NR'($urandom)));
        tr.push_back(mk(0, 0, n, 0, 0, NR'($urandom)));
        m_in = CW'(n);
    endtask

    task automatic abort_at(input int p);
        tr[p].abort = 1'b1;
        while (tr.size() > p + 1) void'(tr.pop_back());
        tr.push_back(mk(0, 0, int'(tr[p].inc), 0, 0, NR'($urandom)));
        m_in = tr[p].inc;
    endtask

    task automatic run_trace(input string tag);
        n_sl = 0;
        foreach (tr[i]) begin
            @(negedge clk);
            check_eq({tag, " op"}, 32'(op), 32'(tr[i].op));
            check_eq({tag, " stage_load"}, 32'(stage_load), 32'(tr[i].sl));
            check_eq({tag, " in_cycle"}, 32'(in_cycle), 32'(tr[i].inc));
            check_eq({tag, " busy"}, 32'(busy), 32'(tr[i].busy));
            check_eq({tag, " finished"}, 32'(finished), 32'(tr[i].fin));
            check_eq({tag, " err"}, 32'(err), 32'd0);
            if (stage_load) n_sl++;
            start      = tr[i].start;
            abort      = tr[i].abort;
            num_cycles = tr[i].num;
            done_vec   = tr[i].done;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, " op"}, 32'(op), 32'd0);
        check_eq({tag, " stage_load"}, 32'(stage_load), 32'd0);
        check_eq({tag, " in_cycle"}, 32'(in_cycle), 32'd0);
        check_eq({tag, " busy"}, 32'(busy), 32'd0);
        check_eq({tag, " finished"}, 32'(finished), 32'd0);
        check_eq({tag, " err"}, 32'(err), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        build_run(3, 1, 1, 1'b0);
        run_trace("three_cycles");
        check_eq("three_cycles stage_load count", 32'(n_sl), 32'd6);

        build_run(0, 0, 0, 1'b0);
        run_trace("zero_cycles");
        check_eq("zero_cycles stage_load count", 32'(n_sl), 32'd0);

`ifndef SEQ_TIMEOUT_EN
        build_run(1, 11, 1, 1'b1);
        run_trace("bit5_late");
`endif

        build_run(3, 1, 1, 1'b0);
        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i].op == OW'(3) && tr[i].inc == CW'(1)) begin
                abort_at(i);
                break;
            end
        end
        run_trace("abort_ph1");
        build_run(2, 0, 0, 1'b0);
        run_trace("restart");

        build_run(15, 1, 1, 1'b0);
        run_trace("max_cycles");

        for (int t = 0; t < 12; t++) begin
            build_run($urandom_range(4, 1), 0, 0, 1'b0);
            if ($urandom_range(2) == 0) abort_at($urandom_range(tr.size() - 2, 1));
            run_trace("random");
        end

        // Watchdog: PH0 with no router ever done
        @(negedge clk);
        start = 1'b1; num_cycles = CW'(1); done_vec = '0;
        @(negedge clk);
        start = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        repeat (8) @(negedge clk);
        check_eq("timeout before op", 32'(op), 32'd2);
        check_eq("timeout before err", 32'(err), 32'd0);
        @(negedge clk);
        check_eq("timeout op", 32'(op), 32'd0);
        check_eq("timeout err", 32'(err), 32'd1);
        check_eq("timeout busy", 32'(busy), 32'd1);
`else
        repeat (20) @(negedge clk);
        check_eq("stall op", 32'(op), 32'd2);
        check_eq("stall busy", 32'(busy), 32'd1);
        check_eq("stall err", 32'(err), 32'd0);
`endif
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("stall abort busy", 32'(busy), 32'd0);
        check_eq("stall abort op", 32'(op), 32'd0);
        check_eq("stall abort in_cycle", 32'(in_cycle), 32'd0);
        m_in = '0;

        // Asynchronous reset in the middle of PH0
        @(negedge clk);
        start = 1'b1; num_cycles = CW'(2); done_vec = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_eq("pre_reset op", 32'(op), 32'd2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_reset busy", 32'(busy), 32'd0);
            check_eq("post_reset finished", 32'(finished), 32'd0);
        end
        m_in = '0;
        build_run(2, 0, 0, 1'b0);
        run_trace("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
